// File: rtl/module_uart_regbank_if.sv
// CPU-side register bus for the UART register bank.
// The master drives the address, strobes and write data.
// The slave (the register bank) returns registered read data.
interface module_uart_regbank_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        addr_i;
  logic              we_i;
  logic              re_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;

  modport master (output addr_i, we_i, re_i, wdata_i, input rdata_o);
  modport slave  (input addr_i, we_i, re_i, wdata_i, output rdata_o);
endinterface

// File: rtl/module_uart_regbank.sv
// UART register bank: CTRL / TXDATA / RXDATA / STATUS registers, RX FIFO,
// and the TX start/busy/done sequencer.
// Optional feature: define UART_REGBANK_IRQ_EN to add the irq_o output and
// make CTRL bit2 (IRQ_EN) writable.
module module_uart_regbank #(
  parameter int DATA_W   = 32,
  parameter int CHAR_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  module_uart_regbank_if.slave bus,
  output logic [CHAR_W-1:0] tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  input  logic [CHAR_W-1:0] rx_data_i,
  input  logic              rx_valid_i
`ifdef UART_REGBANK_IRQ_EN
  ,
  output logic              irq_o
`endif
);
  localparam int PW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} tx_state_t;

  tx_state_t         state, state_nx;
  logic              send, ovf, irq_en;
  logic [CHAR_W-1:0] txdata;
  logic [CHAR_W-1:0] mem [RX_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [DATA_W-1:0] rd_val;

  logic wr_ctrl, wr_tx, rd_rx, empty, full, pop, push, ovf_set, done_evt;

  assign wr_ctrl  = bus.we_i && (bus.addr_i == 2'd0);
  assign wr_tx    = bus.we_i && (bus.addr_i == 2'd1);
  assign rd_rx    = bus.re_i && (bus.addr_i == 2'd2);
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(RX_DEPTH));
  assign pop      = rd_rx && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign push     = rx_valid_i && (!full || pop);
  assign ovf_set  = rx_valid_i && full && !pop;
  // Only a done seen while waiting completes a request; stray pulses are ignored.
  assign done_evt = (state == S_WAIT) && tx_done_i;

  assign tx_data_o = txdata;

  // Upper write-data bits have no storage; fold them away.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata_i;

  // TX sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // TX sequencer next state; tx_start_o is high for the single START cycle.
  always_comb begin
    state_nx   = state;
    tx_start_o = 1'b0;
    case (state)
      S_IDLE:  if (send && !tx_busy_i) state_nx = S_START;
      S_START: begin
        tx_start_o = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT:  if (tx_done_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // CTRL: SEND is set by software and cleared by completion; RX_OVF is sticky, write-1-to-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      send <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (done_evt)                       send <= 1'b0;
      else if (wr_ctrl && bus.wdata_i[0]) send <= 1'b1;
      if (ovf_set)                        ovf  <= 1'b1;
      else if (wr_ctrl && bus.wdata_i[1]) ovf  <= 1'b0;
    end
  end

  // TXDATA: frozen while a request is pending so the character in flight is stable.
  always_ff @(posedge clk_i) begin
    if (rst_i)                txdata <= '0;
    else if (wr_tx && !send)  txdata <= bus.wdata_i[CHAR_W-1:0];
  end

  // RX FIFO storage; no reset needed, validity comes from count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  // RX FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read mux over pre-update state, so same-cycle writes are not visible.
  always_comb begin
    rd_val = '0;
    case (bus.addr_i)
      2'd0: rd_val[2:0] = {irq_en, ovf, send};
      2'd1: rd_val[CHAR_W-1:0] = txdata;
      2'd2: if (!empty) begin
        rd_val[DATA_W-1]   = 1'b1;
        rd_val[CHAR_W-1:0] = mem[rd_ptr];
      end
      default: begin
        rd_val[PW:0] = count;
        rd_val[16]   = !empty;
        rd_val[17]   = full;
        rd_val[18]   = (state != S_IDLE);
      end
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i)          bus.rdata_o <= '0;
    else if (bus.re_i)  bus.rdata_o <= rd_val;
  end

`ifdef UART_REGBANK_IRQ_EN
  logic done_lat;

  // IRQ_EN bit and the TX-done event latch (cleared by any CTRL write).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en   <= 1'b0;
      done_lat <= 1'b0;
    end else begin
      if (wr_ctrl)       irq_en   <= bus.wdata_i[2];
      if (done_evt)      done_lat <= 1'b1;
      else if (wr_ctrl)  done_lat <= 1'b0;
    end
  end

  // Registered interrupt output.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= irq_en && (!empty || ovf || done_lat);
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_module_uart_regbank.sv
// Self-checking bench for module_uart_regbank: directed scenarios plus a
// randomized RX/register phase checked against a queue-based model.
module tb_module_uart_regbank;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic [CW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
`ifdef UART_REGBANK_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  module_uart_regbank_if #(.DATA_W(DW)) bus ();

  module_uart_regbank #(.DATA_W(DW), .CHAR_W(CW), .RX_DEPTH(DEP)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy),
    .tx_done_i  (tx_done),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid)
`ifdef UART_REGBANK_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;
  int n_start = 0;

  always @(negedge clk) if (tx_start) n_start++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr_i = a; bus.wdata_i = d; bus.we_i = 1'b1;
    cyc();
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr_i = a; bus.re_i = 1'b1;
    cyc();
    bus.re_i = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic push(input logic [7:0] c);
    rx_data = c; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  logic [31:0] r, exp_rd, last_rd;
  logic [7:0]  expq[$];
  logic [7:0]  mq[$];
  logic        movf;
  int          s0;

  initial begin
    bus.addr_i = '0; bus.we_i = 1'b0; bus.re_i = 1'b0; bus.wdata_i = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_start", tx_start, 1'b0);
    rd(2'd0, r); chk("rst_ctrl", r, 32'h0);
    rd(2'd1, r); chk("rst_txdata", r, 32'h0);
    rd(2'd2, r); chk("rst_rxdata", r, 32'h0);
    rd(2'd3, r); chk("rst_status", r, 32'h0);
    chk("rst_nstart", n_start, 0);

    // Basic transmit
    wr(2'd1, 32'h41);
    wr(2'd0, 32'h1);
    chk("tx_not_yet", tx_start, 1'b0);
    cyc();
    chk("tx_start_hi", tx_start, 1'b1);
    chk("tx_data", tx_data, 8'h41);
    cyc();
    chk("tx_start_lo", tx_start, 1'b0);
    wr(2'd1, 32'h42);
    rd(2'd1, r); chk("tx_wr_ignored", r, 32'h41);
    chk("tx_data_stable", tx_data, 8'h41);
    rd(2'd3, r); chk("tx_busy_stat", r, 32'h40000);
    rd(2'd0, r); chk("tx_send_set", r, 32'h1);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    rd(2'd0, r); chk("tx_send_clr", r, 32'h0);
    rd(2'd3, r); chk("tx_idle_stat", r, 32'h0);
    chk("tx_one_pulse", n_start, 1);

    // Engine busy holds off start
    tx_busy = 1'b1;
    wr(2'd1, 32'h55);
    wr(2'd0, 32'h1);
    repeat (3) cyc();
    chk("busy_hold", n_start, 1);
    tx_busy = 1'b0;
    cyc();
    chk("busy_rel_start", tx_start, 1'b1);
    chk("busy_rel_data", tx_data, 8'h55);
    cyc();
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    rd(2'd0, r); chk("busy_done", r, 32'h0);

    // RX FIFO basic
    push(8'h11); push(8'h22); push(8'h33);
    rd(2'd3, r); chk("rx_cnt3", r, 32'h10003);
    rd(2'd2, r); chk("rx_pop0", r, 32'h80000011);
    rd(2'd2, r); chk("rx_pop1", r, 32'h80000022);
    rd(2'd2, r); chk("rx_pop2", r, 32'h80000033);
    rd(2'd2, r); chk("rx_pop_empty", r, 32'h0);
    rd(2'd3, r); chk("rx_cnt0", r, 32'h0);

    // Overflow
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    rd(2'd3, r); chk("ovf_full", r, 32'h30004);
    rd(2'd0, r); chk("ovf_flag", r, 32'h2);
    wr(2'd0, 32'h2);
    rd(2'd0, r); chk("ovf_clr", r, 32'h0);

    // Full FIFO with simultaneous push and pop, across pointer wrap
    expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'hB0 + 8'(i); rx_valid = 1'b1;
      bus.addr_i = 2'd2; bus.re_i = 1'b1;
      cyc();
      rx_valid = 1'b0; bus.re_i = 1'b0;
      chk("pp_data", bus.rdata_o, 32'h80000000 | 32'(expq.pop_front()));
      expq.push_back(8'hB0 + 8'(i));
      rd(2'd3, r); chk("pp_full", r, 32'h30004);
      rd(2'd0, r); chk("pp_noovf", r, 32'h0);
    end
    for (int i = 0; i < DEP; i++) begin
      rd(2'd2, r); chk("pp_drain", r, 32'h80000000 | 32'(expq.pop_front()));
    end
    rd(2'd3, r); chk("pp_empty", r, 32'h0);

    // Reset during WAIT
    wr(2'd1, 32'h77);
    wr(2'd0, 32'h1);
    cyc(); cyc();
    push(8'h12); push(8'h34);
    rd(2'd3, r); chk("rw_pre", r, 32'h50002);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rw_rdata", bus.rdata_o, 32'h0);
    chk("rw_start", tx_start, 1'b0);
    s0 = n_start;
    rd(2'd3, r); chk("rw_status", r, 32'h0);
    rd(2'd0, r); chk("rw_ctrl", r, 32'h0);
    rd(2'd1, r); chk("rw_txdata", r, 32'h0);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    repeat (4) cyc();
    chk("rw_nostart", n_start, s0);
    rd(2'd0, r); chk("rw_ctrl2", r, 32'h0);

    // Randomized RX / register traffic vs queue model
    movf = 1'b0;
    last_rd = bus.rdata_o;
    for (int n = 0; n < 600; n++) begin
      logic v, re_b, clr;
      logic [1:0] a;
      logic [7:0] c;
      v    = ($urandom_range(0, 99) < 40);
      c    = 8'($urandom);
      re_b = ($urandom_range(0, 99) < 50);
      clr  = !v && ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 3))
        0: a = 2'd0;
        3: a = 2'd3;
        default: a = 2'd2;
      endcase
      if (clr) a = 2'd0;
      exp_rd = 32'h0;
      if (a == 2'd0) exp_rd = {30'h0, movf, 1'b0};
      else if (a == 2'd2) exp_rd = (mq.size() > 0) ? (32'h80000000 | 32'(mq[0])) : 32'h0;
      else exp_rd = 32'(mq.size()) | ((mq.size() > 0) ? 32'h10000 : 32'h0)
                    | ((mq.size() == DEP) ? 32'h20000 : 32'h0);
      if (re_b && a == 2'd2 && mq.size() > 0) void'(mq.pop_front());
      if (clr) movf = 1'b0;
      if (v) begin
        if (mq.size() < DEP) mq.push_back(c);
        else movf = 1'b1;
      end
      bus.addr_i = a; bus.re_i = re_b; bus.we_i = clr; bus.wdata_i = 32'h2;
      rx_data = c; rx_valid = v;
      cyc();
      bus.re_i = 1'b0; bus.we_i = 1'b0; rx_valid = 1'b0;
      if (re_b) begin
        chk("rnd_rd", bus.rdata_o, exp_rd);
        last_rd = exp_rd;
      end else begin
        chk("rnd_hold", bus.rdata_o, last_rd);
      end
    end
    rd(2'd3, r);
    chk("rnd_final", r, 32'(mq.size()) | ((mq.size() > 0) ? 32'h10000 : 32'h0)
                        | ((mq.size() == DEP) ? 32'h20000 : 32'h0));

`ifdef UART_REGBANK_IRQ_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("irq_rst", irq, 1'b0);
    wr(2'd0, 32'h4);
    chk("irq_idle", irq, 1'b0);
    push(8'h5A);
    cyc();
    chk("irq_rx", irq, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("irq_rst2", irq, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
